// File: rtl/cam_search_ctrl.sv
// CAM search controller: arbitrates write/search requests, drives the cell array,
// owns the per-entry valid bits and returns a priority-encoded result.
// Optional: define CAM_MULTI_HIT_EN to add the result_multi_o output.
module cam_search_ctrl #(
    parameter int NUM_ENTRIES = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int IDX_WIDTH   = $clog2(NUM_ENTRIES)
) (
    input  logic                   clk_i,
    input  logic                   reset,
    input  logic                   write_valid_i,
    output logic                   write_ready_o,
    input  logic [IDX_WIDTH-1:0]   write_index_i,
    input  logic [DATA_WIDTH-1:0]  write_data_i,
    input  logic                   write_invalidate_i,
    input  logic                   search_valid_i,
    output logic                   search_ready_o,
    input  logic [DATA_WIDTH-1:0]  search_data_i,
    output logic                   result_valid_o,
    input  logic                   result_ready_i,
    output logic                   result_hit_o,
    output logic [IDX_WIDTH-1:0]   result_index_o,
`ifdef CAM_MULTI_HIT_EN
    output logic                   result_multi_o,
`endif
    output logic [NUM_ENTRIES-1:0] cell_write_enable_o,
    output logic [DATA_WIDTH-1:0]  cell_data_o,
    output logic                   cell_search_enable_o,
    output logic [DATA_WIDTH-1:0]  cell_search_o,
    input  logic [NUM_ENTRIES-1:0] cell_match_i
);

    typedef enum logic [1:0] {IDLE, WRITE, SEARCH, RESP} state_e;

    state_e                 state_q, state_d;
    logic [NUM_ENTRIES-1:0] valid_q;
    logic [IDX_WIDTH-1:0]   wr_idx_q;
    logic [DATA_WIDTH-1:0]  cell_data_q;
    logic [DATA_WIDTH-1:0]  search_key_q;
    logic                   hit_q;
    logic [IDX_WIDTH-1:0]   index_q;

    logic                   write_fire;
    logic                   search_fire;
    logic [NUM_ENTRIES-1:0] masked;
    logic [IDX_WIDTH-1:0]   lowest_idx;

    assign write_fire  = write_valid_i && write_ready_o;
    assign search_fire = search_valid_i && search_ready_o;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every always_comb target gets a default first; a missed branch would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (write_fire && !write_invalidate_i) state_d = WRITE;
                else if (search_fire)                  state_d = SEARCH;
            end
            WRITE:   state_d = IDLE;
            SEARCH:  state_d = RESP;
            RESP:    if (result_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Readiness is masked by reset so nothing is accepted in the reset cycle.
    always_comb begin
        write_ready_o        = 1'b0;
        search_ready_o       = 1'b0;
        result_valid_o       = 1'b0;
        cell_write_enable_o  = '0;
        cell_search_enable_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                write_ready_o  = !reset;
                search_ready_o = !reset && !write_valid_i;
            end
            WRITE:   cell_write_enable_o[wr_idx_q] = 1'b1;
            SEARCH:  cell_search_enable_o = 1'b1;
            RESP:    result_valid_o = 1'b1;
            default: ;
        endcase
    end

    // Only valid entries may hit; the lowest matching index wins.
    always_comb begin
        masked     = cell_match_i & valid_q;
        lowest_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (masked[i]) lowest_idx = IDX_WIDTH'(i);
        end
    end

    // NOTE: the valid bits are reset because they alone define hit semantics; cell contents are not.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            valid_q      <= '0;
            wr_idx_q     <= '0;
            cell_data_q  <= '0;
            search_key_q <= '0;
            hit_q        <= 1'b0;
            index_q      <= '0;
        end else begin
            if (write_fire) begin
                if (write_invalidate_i) begin
                    valid_q[write_index_i] <= 1'b0;
                end else begin
                    wr_idx_q    <= write_index_i;
                    cell_data_q <= write_data_i;
                end
            end
            if (state_q == WRITE) valid_q[wr_idx_q] <= 1'b1;
            if (search_fire)      search_key_q      <= search_data_i;
            if (state_q == SEARCH) begin
                hit_q   <= |masked;
                index_q <= lowest_idx;
            end
        end
    end

`ifdef CAM_MULTI_HIT_EN
    logic multi_q;

    // Clearing the lowest set bit leaves something only if two or more entries matched.
    always_ff @(posedge clk_i) begin
        if (reset)                  multi_q <= 1'b0;
        else if (state_q == SEARCH) multi_q <= |(masked & (masked - NUM_ENTRIES'(1)));
    end

    assign result_multi_o = multi_q;
`endif

    assign cell_data_o    = cell_data_q;
    assign cell_search_o  = search_key_q;
    assign result_hit_o   = hit_q;
    assign result_index_o = index_q;

endmodule

// File: tb/tb_cam_search_ctrl.sv
// Bench for cam_search_ctrl: behavioural cell array, directed table, hand sequences
// for reset/arbitration corners, and randomized traffic against an entry-list model.
module tb_cam_search_ctrl;

    localparam int N  = 32;
    localparam int DW = 32;
    localparam int IW = 5;

    logic          clk_i = 1'b0;
    logic          reset;
    logic          write_valid_i;
    logic          write_ready_o;
    logic [IW-1:0] write_index_i;
    logic [DW-1:0] write_data_i;
    logic          write_invalidate_i;
    logic          search_valid_i;
    logic          search_ready_o;
    logic [DW-1:0] search_data_i;
    logic          result_valid_o;
    logic          result_ready_i;
    logic          result_hit_o;
    logic [IW-1:0] result_index_o;
`ifdef CAM_MULTI_HIT_EN
    logic          result_multi_o;
`endif
    logic [N-1:0]  cell_write_enable_o;
    logic [DW-1:0] cell_data_o;
    logic          cell_search_enable_o;
    logic [DW-1:0] cell_search_o;
    logic [N-1:0]  cell_match_i;

    cam_search_ctrl #(.NUM_ENTRIES(N), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
        .clk_i(clk_i), .reset(reset),
        .write_valid_i(write_valid_i), .write_ready_o(write_ready_o),
        .write_index_i(write_index_i), .write_data_i(write_data_i),
        .write_invalidate_i(write_invalidate_i),
        .search_valid_i(search_valid_i), .search_ready_o(search_ready_o),
        .search_data_i(search_data_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_hit_o(result_hit_o), .result_index_o(result_index_o),
`ifdef CAM_MULTI_HIT_EN
        .result_multi_o(result_multi_o),
`endif
        .cell_write_enable_o(cell_write_enable_o), .cell_data_o(cell_data_o),
        .cell_search_enable_o(cell_search_enable_o), .cell_search_o(cell_search_o),
        .cell_match_i(cell_match_i)
    );

    always #5 clk_i = ~clk_i;

    // Cell array: stores on its write enable, compares combinationally against the key.
    logic [DW-1:0] cell_mem [N] = '{default: 32'hFFFF_FF00};
    always @(posedge clk_i) begin
        for (int i = 0; i < N; i++) if (cell_write_enable_o[i]) cell_mem[i] <= cell_data_o;
    end
    always_comb begin
        cell_match_i = '0;
        for (int i = 0; i < N; i++) cell_match_i[i] = (cell_mem[i] == cell_search_o);
    end

    // Reference model: which entries are valid and what they hold.
    bit   [N-1:0]  model_valid;
    logic [DW-1:0] model_data [N];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_expect(input logic [DW-1:0] key, output logic hit,
                                         output logic [IW-1:0] idx, output logic multi);
        int cnt = 0;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (model_valid[i] && model_data[i] == key) begin
                if (cnt == 0) idx = IW'(i);
                cnt++;
            end
        end
        hit   = (cnt > 0);
        multi = (cnt > 1);
    endfunction

    // Called at a falling edge; returns at a falling edge with the controller back in IDLE.
    task automatic do_write(input logic [IW-1:0] idx, input logic [DW-1:0] data, input logic inv);
        int waited = 0;
        logic [N-1:0] exp_we;
        write_valid_i = 1'b1; write_index_i = idx; write_data_i = data; write_invalidate_i = inv;
        #1;
        while (!write_ready_o && waited < 10) begin @(negedge clk_i); #1; waited++; end
        check("write_accept", write_ready_o, 1);
        @(negedge clk_i);
        if (inv) begin
            check("inv_no_cell_we", cell_write_enable_o, 0);
            check("inv_stays_idle", write_ready_o, 1);
            write_valid_i = 1'b0;
            model_valid[idx] = 1'b0;
        end else begin
            exp_we = '0;
            exp_we[idx] = 1'b1;
            check("write_we_onehot", cell_write_enable_o, exp_we);
            check("write_cell_data", cell_data_o, data);
            check("write_busy_ready", {write_ready_o, search_ready_o}, 0);
            write_valid_i = 1'b0;
            @(negedge clk_i);
            check("write_back_idle", write_ready_o, 1);
            check("write_we_cleared", cell_write_enable_o, 0);
            model_valid[idx] = 1'b1;
            model_data[idx]  = data;
        end
    endtask

    // Runs one search, holding result_ready_i low for 'hold' RESP cycles.
    task automatic do_search(input logic [DW-1:0] key, input int hold, input logic e_hit,
                             input logic [IW-1:0] e_idx, input logic e_multi);
        int waited = 0;
        search_valid_i = 1'b1; search_data_i = key; result_ready_i = 1'b0;
        #1;
        while (!search_ready_o && waited < 10) begin @(negedge clk_i); #1; waited++; end
        check("search_accept", search_ready_o, 1);
        @(negedge clk_i);
        check("search_enable", cell_search_enable_o, 1);
        check("search_key_bcast", cell_search_o, key);
        check("search_no_result_yet", result_valid_o, 0);
        check("search_busy_ready", {write_ready_o, search_ready_o}, 0);
        search_valid_i = 1'b0;
        @(negedge clk_i);
        check("result_valid_k2", result_valid_o, 1);
        check("result_hit", result_hit_o, e_hit);
        check("result_index", result_index_o, e_idx);
`ifdef CAM_MULTI_HIT_EN
        check("result_multi", result_multi_o, e_multi);
`endif
        check("search_enable_off", cell_search_enable_o, 0);
        for (int c = 0; c < hold; c++) begin
            @(negedge clk_i);
            check("hold_valid", result_valid_o, 1);
            check("hold_fields", {result_hit_o, result_index_o}, {e_hit, e_idx});
            check("hold_ready_low", {write_ready_o, search_ready_o}, 0);
        end
        result_ready_i = 1'b1;
        @(negedge clk_i);
        check("resp_released", result_valid_o, 0);
        check("idle_after_resp", write_ready_o, 1);
        result_ready_i = 1'b0;
    endtask

    typedef struct {
        logic          is_search;
        logic          inv;
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
        logic          e_hit;
        logic [IW-1:0] e_idx;
        logic          e_multi;
        int            hold;
    } vec_t;

    vec_t vecs [14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          e_hit, e_multi;
        logic [IW-1:0] e_idx;
        logic [DW-1:0] pool [4];

        vecs[0]  = '{0, 0, 5,  32'hDEADBEEF, 0, 0,  0, 0};
        vecs[1]  = '{1, 0, 0,  32'hDEADBEEF, 1, 5,  0, 0};
        vecs[2]  = '{0, 0, 3,  32'h0000_1234, 0, 0,  0, 0};
        vecs[3]  = '{0, 0, 9,  32'h0000_1234, 0, 0,  0, 0};
        vecs[4]  = '{1, 0, 0,  32'h0000_1234, 1, 3,  1, 4};
        vecs[5]  = '{0, 1, 5,  32'h0,         0, 0,  0, 0};
        vecs[6]  = '{1, 0, 0,  32'hDEADBEEF, 0, 0,  0, 0};
        vecs[7]  = '{0, 0, 31, 32'hA5A5A5A5, 0, 0,  0, 0};
        vecs[8]  = '{1, 0, 0,  32'hA5A5A5A5, 1, 31, 0, 1};
        vecs[9]  = '{0, 0, 0,  32'hA5A5A5A5, 0, 0,  0, 0};
        vecs[10] = '{1, 0, 0,  32'hA5A5A5A5, 1, 0,  1, 0};
        vecs[11] = '{0, 0, 3,  32'h0000_5555, 0, 0,  0, 0};
        vecs[12] = '{1, 0, 0,  32'h0000_1234, 1, 9,  0, 2};
        vecs[13] = '{1, 0, 0,  32'h0000_5555, 1, 3,  0, 0};

        reset = 1'b1;
        write_valid_i = 1'b0; write_index_i = '0; write_data_i = '0; write_invalidate_i = 1'b0;
        search_valid_i = 1'b0; search_data_i = '0; result_ready_i = 1'b0;
        model_valid = '0;

        repeat (2) @(negedge clk_i);
        check("rst_write_ready_low", write_ready_o, 0);
        check("rst_outputs_zero", {search_ready_o, result_valid_o, cell_write_enable_o,
                                   cell_search_enable_o}, 0);
        reset = 1'b0;
        #1;
        check("post_rst_write_ready", write_ready_o, 1);
        check("post_rst_search_ready", search_ready_o, 1);
        check("post_rst_result", {result_valid_o, result_hit_o, result_index_o}, 0);
        check("post_rst_cell_bus", {cell_data_o, cell_search_o}, 0);
        @(negedge clk_i);

        for (int v = 0; v < 14; v++) begin
            if (vecs[v].is_search)
                do_search(vecs[v].data, vecs[v].hold, vecs[v].e_hit, vecs[v].e_idx, vecs[v].e_multi);
            else
                do_write(vecs[v].idx, vecs[v].data, vecs[v].inv);
        end

        // Write and search requested together: the write wins, the search follows.
        write_valid_i = 1'b1; write_index_i = 7; write_data_i = 32'h7777_0007; write_invalidate_i = 1'b0;
        search_valid_i = 1'b1; search_data_i = 32'h7777_0007;
        #1;
        check("arb_search_blocked", search_ready_o, 0);
        check("arb_write_ready", write_ready_o, 1);
        @(negedge clk_i);
        check("arb_write_cycle_we", cell_write_enable_o[7], 1);
        check("arb_no_search_in_write", cell_search_enable_o, 0);
        write_valid_i = 1'b0;
        @(negedge clk_i);
        check("arb_search_ready_after", search_ready_o, 1);
        model_valid[7] = 1'b1; model_data[7] = 32'h7777_0007;
        do_search(32'h7777_0007, 0, 1, 7, 0);

        // Reset while a search is in flight after one write.
        do_write(2, 32'h0000_CAFE, 0);
        search_valid_i = 1'b1; search_data_i = 32'h0000_CAFE;
        @(negedge clk_i);
        check("pre_reset_in_search", cell_search_enable_o, 1);
        search_valid_i = 1'b0;
        reset = 1'b1;
        @(negedge clk_i);
        check("midrst_write_ready_low", write_ready_o, 0);
        check("midrst_no_result", result_valid_o, 0);
        reset = 1'b0;
        model_valid = '0;
        #1;
        check("midrst_idle", write_ready_o, 1);
        check("midrst_result_cleared", {result_valid_o, result_hit_o, result_index_o}, 0);
        @(negedge clk_i);
        do_search(32'h0000_CAFE, 0, 0, 0, 0);

        // Randomized traffic over a small key pool so hits and multi-hits are common.
        pool[0] = 32'h1111_1111; pool[1] = 32'h2222_2222;
        pool[2] = 32'h3333_3333; pool[3] = 32'hDEADBEEF;
        for (int t = 0; t < 200; t++) begin
            int op;
            logic [IW-1:0] ridx;
            logic [DW-1:0] rkey;
            op   = int'($urandom_range(0, 9));
            ridx = IW'($urandom_range(0, N - 1));
            rkey = pool[$urandom_range(0, 3)];
            if (op < 4) begin
                do_write(ridx, rkey, 0);
            end else if (op == 4) begin
                do_write(ridx, '0, 1);
            end else begin
                model_expect(rkey, e_hit, e_idx, e_multi);
                do_search(rkey, int'($urandom_range(0, 2)), e_hit, e_idx, e_multi);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
